// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
//   XLEN          : width of the instruction and PC fields held in the fetch queue
//   PC_STEP       : byte distance between consecutive sequential fetches
//   fetch_entry_t : one fetched instruction together with the address it came from
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Instruction queue for the fetch unit: circular buffer with head/tail pointers
// and an occupancy count. Push and pop are synchronous; flush empties the queue
// at the next clock edge and takes priority over push/pop.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   flush_i        : drop every stored entry
//   push_i / push_data_i : write one entry at the tail
//   pop_i          : retire the head entry
//   head_o         : current head entry (zero after reset)
//   count_o        : number of valid entries
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer advance that also works for depths that are not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and count.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[tail_q] = push_data_i;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop_i) begin
                head_d = ptr_inc(head_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single-outstanding request
// to a fixed one-cycle-latency instruction memory, and a small queue feeding
// the decoder with a valid/ready handshake. A redirect flushes everything and
// restarts fetch at the word-aligned target on the following cycle.
// Optional feature macro: FETCH_UNIT_PERF_CNT_EN adds fetched_cnt_o and
// flushed_cnt_o (transfers to the decoder / entries dropped by redirect).
// Ports:
//   clk_i, rst_i                    : clock, asynchronous active-high reset
//   imem_re_o, imem_raddr_o         : memory read request and byte address
//   imem_rdata_i                    : read data, one cycle after the request
//   redirect_i, redirect_pc_i       : flush and restart fetch at target
//   inst_o, pc_o, valid_o, ready_i  : head-of-queue instruction to the decoder
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = DATAWIDTH'(32'h0000_0000),
    parameter int unsigned          QDEPTH    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_re_o,
    output logic [DATAWIDTH-1:0] imem_raddr_o,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    output logic [DATAWIDTH-1:0] inst_o,
    output logic [DATAWIDTH-1:0] pc_o,
    output logic                 valid_o,
`ifdef FETCH_UNIT_PERF_CNT_EN
    output logic [31:0]          fetched_cnt_o,
    output logic [31:0]          flushed_cnt_o,
`endif
    input  logic                 ready_i
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [DATAWIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]     fifo_count;
    fetch_entry_t         fifo_head;
    fetch_entry_t         push_entry;
    logic                 push;
    logic                 pop;
    logic [OCC_W-1:0]     occ_after_pop;

    // Decoder handshake; a redirect kills the transfer in the same cycle.
    assign valid_o = (fifo_count != '0) & ~redirect_i;
    assign pop     = valid_o & ready_i;
    assign inst_o  = DATAWIDTH'(fifo_head.inst);
    assign pc_o    = DATAWIDTH'(fifo_head.pc);

    // Request only if the response is guaranteed a free slot when it lands.
    assign occ_after_pop = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign imem_re_o     = ~rst_i & ~redirect_i & (occ_after_pop < OCC_W'(QDEPTH));
    assign imem_raddr_o  = pc_q;

    // A response arriving during a redirect belongs to the old stream: drop it.
    assign push            = inflight_q & ~redirect_i;
    assign push_entry.inst = XLEN'(imem_rdata_i);
    assign push_entry.pc   = XLEN'(inflight_pc_q);

    // PC and in-flight tracking.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
        end else if (imem_re_o) begin
            pc_d          = pc_q + DATAWIDTH'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    // Flushed count covers both queued entries and the response in flight.
    always_comb begin
        fetched_d = fetched_q + 32'(pop);
        flushed_d = flushed_q;
        if (redirect_i) begin
            flushed_d = flushed_q + 32'(fifo_count) + 32'(inflight_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign fetched_cnt_o = fetched_q;
    assign flushed_cnt_o = flushed_q;
`endif

endmodule : fetch_unit
